input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Conditions raw board inputs (slide switches, push keys) before they reach the Nios-II system PIO inputs.
- Per bit: two-flop synchronizer into the 50 MHz domain, then a counter-based debouncer, then registered rise/fall pulses.
- Provides a sticky per-bit change flag that software-facing logic clears with a mask.
- Instantiated in the board top between the switch/key pins and the cpu_system PIO exports.

Parameters:
- WIDTH, 10, number of conditioned inputs.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (20 ms at 50 MHz). Legal range is ≥1; elaboration error otherwise.
- RESET_VALUE, '0, WIDTH-bit level loaded into the synchronizers and the stable register at reset. Use '1 for the active-low keys.

Ports:
- clk_clk  input  1  system clock, 50 MHz.
- reset_reset_n  input  1  reset; asynchronous assert, active-low.
- raw_in  input  WIDTH  asynchronous pin levels.
- clear_changed  input  WIDTH  per-bit clear mask for changed, sampled every cycle.
- stable_out  output  WIDTH  debounced level.
- rise_out  output  WIDTH  one-cycle pulse when stable_out goes 0→1.
- fall_out  output  WIDTH  one-cycle pulse when stable_out goes 1→0.
- changed  output  WIDTH  sticky flag; set on any stable_out transition.

Behaviour:
- One clock, clk_clk. reset_reset_n is asynchronous, active-low. All flops reset asynchronously; release is used as delivered.
- Reset values:
  - sync1, sync2, stable_out = RESET_VALUE.
  - Counters = 0.
  - rise_out, fall_out, changed = 0.
  - Consequence: no spurious edge is reported after reset.
- Synchronizer: sync1 <= raw_in, then sync2 <= sync1 at each edge.
- Per-bit counter cnt, width $clog2(DEBOUNCE_CYCLES+1), minimum 1:
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
- Latency: raw_in changes before edge k and is held. stable_out changes at edge k+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=1 this is k+2 (synchronizer only).
- Glitch rejection: if sync2 returns to stable before the count completes, cnt clears and no output changes. Any pulse shorter than DEBOUNCE_CYCLES cycles at sync2 is ignored.
- Pulses:
  - rise_out and fall_out are registered and asserted in the same cycle that stable_out takes its new value, high for exactly one cycle.
  - Never both high on one bit.
- changed[i]:
  - Set on the cycle rise_out[i] or fall_out[i] asserts.
  - Otherwise cleared when clear_changed[i]=1.
  - Set and clear on the same cycle: set wins, so the event is not lost.
- Bits are fully independent; simultaneous transitions on several bits are all reported in the same cycle.
- Counter never wraps: it saturates at DEBOUNCE_CYCLES-1 and clears on acceptance.
- Reset mid-count: state returns to the reset values. A level differing from RESET_VALUE is re-debounced after release and reported as an edge.

Decomposition:
- Package input_conditioner_pkg:
  - cnt_width(int) constant function.
  - Default DEBOUNCE_CYCLES_20MS = 1_000_000.
  - CLK_HZ = 50_000_000.
- Sub-module debounce_bit: one synchronizer, counter, stable flop and edge pulse. Generated WIDTH times.
- The changed logic stays in input_conditioner.

Test Plan (sim with WIDTH=4, DEBOUNCE_CYCLES=8, RESET_VALUE=4'b0000 unless noted):
- Reset, then raw_in=0 held for 20 cycles -> stable_out=0, no rise_out/fall_out/changed activity.
- raw_in[0] 0→1 before edge k, held -> stable_out[0]=1 at edge k+9. rise_out[0]=1 for exactly that cycle. changed=4'b0001 from then on.
- raw_in[1] high for 5 cycles, then low -> stable_out, rise_out and changed all stay 0. Repeat with a 7-cycle high: still nothing. Repeat with an 8-cycle high: rise_out[1] fires.
- raw_in 4'b1111 applied together -> rise_out=4'b1111 in one cycle. Next cycle clear_changed=4'b0101 gives changed=4'b1010.
- clear_changed[2]=1 asserted on the same cycle fall_out[2] pulses -> changed[2]=1 afterwards (set wins).
- RESET_VALUE=4'b1111, raw_in=4'b1111 through reset -> stable_out=4'b1111 and no fall_out. Then reset is asserted mid-count after raw_in[3] drops for 4 cycles -> after release, fall_out[3] fires at release+9 cycles.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg -- shared constants and sizing helpers for the input conditioner.
// Rev 1.0
`default_nettype none

package input_conditioner_pkg;

    localparam int CLK_HZ               = 50_000_000;
    localparam int DEBOUNCE_CYCLES_20MS = 1_000_000;

    // The counter must reach DEBOUNCE_CYCLES-1 and is never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/input_conditioner_if.sv
// input_conditioner_if -- pin-side levels, clear mask and conditioned outputs.
// Rev 1.0
`default_nettype none

interface input_conditioner_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clear_changed;
    logic [WIDTH-1:0] stable_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;
    logic [WIDTH-1:0] changed;

    modport master (
        output raw_in,
        output clear_changed,
        input  stable_out,
        input  rise_out,
        input  fall_out,
        input  changed
    );

    modport slave (
        input  raw_in,
        input  clear_changed,
        output stable_out,
        output rise_out,
        output fall_out,
        output changed
    );
endinterface

`default_nettype wire

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit -- two-flop synchronizer, saturating debounce counter, stable level and edge pulses.
// Rev 1.0
`default_nettype none

module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = i_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Counter only runs while the synchronized level disagrees; any agreement restarts it.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
                fall_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RESET_VALUE;
            sync2_q  <= RESET_VALUE;
            stable_q <= RESET_VALUE;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign o_stable = stable_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// input_conditioner -- per-bit synchronize/debounce of board inputs with edge pulses and sticky change flags.
// Rev 1.0
`default_nettype none

module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int               WIDTH           = 10,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  wire             clk_clk,
    input  wire             reset_reset_n,
    input_conditioner_if.slave bus
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_debounce (
            .clk      (clk_clk),
            .rst_n    (reset_reset_n),
            .i_raw    (bus.raw_in[i]),
            .o_stable (stable_w[i]),
            .o_rise   (rise_w[i]),
            .o_fall   (fall_w[i])
        );
    end

    // A pulse visible this cycle overrides a simultaneous clear so no event is dropped.
    always_comb begin
        changed_d = (changed_q & ~bus.clear_changed) | rise_w | fall_w;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            changed_q <= '0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.stable_out = stable_w;
    assign bus.rise_out   = rise_w;
    assign bus.fall_out   = fall_w;
    assign bus.changed    = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner -- directed scenarios plus random toggling, checked against a run-length reference model.
// Rev 1.0
`default_nettype none

module tb_input_conditioner;

    localparam int D = 8;

    logic clk;
    logic rst_n;
    logic [3:0] raw [2];
    logic [3:0] clr [2];

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner_if #(.WIDTH(4)) bus0 ();
    input_conditioner_if #(.WIDTH(4)) bus1 ();

    assign bus0.raw_in        = raw[0];
    assign bus0.clear_changed = clr[0];
    assign bus1.raw_in        = raw[1];
    assign bus1.clear_changed = clr[1];

    input_conditioner #(
        .WIDTH(4), .DEBOUNCE_CYCLES(D), .RESET_VALUE(4'b0000)
    ) u_dut0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .bus(bus0)
    );

    input_conditioner #(
        .WIDTH(4), .DEBOUNCE_CYCLES(D), .RESET_VALUE(4'b1111)
    ) u_dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a two-stage delay line, then a level is accepted once it has
    // disagreed with the current stable level for D consecutive samples.
    logic [3:0] m_s1 [2], m_s2 [2], m_stab [2], m_rise [2], m_fall [2], m_chg [2];
    int         m_run [2][4];
    logic [3:0] m_rv [2];
    logic [3:0] m_nr, m_nf;

    initial begin
        m_rv[0] = 4'b0000;
        m_rv[1] = 4'b1111;
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_s1[i]   = m_rv[i];
                m_s2[i]   = m_rv[i];
                m_stab[i] = m_rv[i];
                m_rise[i] = '0;
                m_fall[i] = '0;
                m_chg[i]  = '0;
                for (int b = 0; b < 4; b++) m_run[i][b] = 0;
            end else begin
                m_chg[i] = (m_chg[i] & ~clr[i]) | m_rise[i] | m_fall[i];
                m_nr = '0;
                m_nf = '0;
                for (int b = 0; b < 4; b++) begin
                    if (m_s2[i][b] != m_stab[i][b]) begin
                        m_run[i][b] = m_run[i][b] + 1;
                        if (m_run[i][b] == D) begin
                            m_stab[i][b] = m_s2[i][b];
                            m_run[i][b]  = 0;
                            if (m_s2[i][b]) m_nr[b] = 1'b1;
                            else            m_nf[b] = 1'b1;
                        end
                    end else begin
                        m_run[i][b] = 0;
                    end
                end
                m_rise[i] = m_nr;
                m_fall[i] = m_nf;
                m_s2[i]   = m_s1[i];
                m_s1[i]   = raw[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("u0.stable",  32'(bus0.stable_out), 32'(m_stab[0]));
        check("u0.rise",    32'(bus0.rise_out),   32'(m_rise[0]));
        check("u0.fall",    32'(bus0.fall_out),   32'(m_fall[0]));
        check("u0.changed", 32'(bus0.changed),    32'(m_chg[0]));
        check("u1.stable",  32'(bus1.stable_out), 32'(m_stab[1]));
        check("u1.rise",    32'(bus1.rise_out),   32'(m_rise[1]));
        check("u1.fall",    32'(bus1.fall_out),   32'(m_fall[1]));
        check("u1.changed", 32'(bus1.changed),    32'(m_chg[1]));
    endtask

    task automatic pulse_bit1(input int n);
        raw[0][1] = 1'b1;
        repeat (n) tick();
        raw[0][1] = 1'b0;
        repeat (15) tick();
    endtask

    int hold [2][4];

    initial begin
        rst_n  = 1'b0;
        raw[0] = 4'b0000;
        raw[1] = 4'b1111;
        clr[0] = 4'b0000;
        clr[1] = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst.stable0", 32'(bus0.stable_out), 32'h0);
        check("rst.stable1", 32'(bus1.stable_out), 32'hF);
        check("rst.pulses0", 32'(bus0.rise_out | bus0.fall_out | bus0.changed), 32'h0);
        check("rst.pulses1", 32'(bus1.rise_out | bus1.fall_out | bus1.changed), 32'h0);
        rst_n = 1'b1;

        repeat (20) tick();
        check("idle.changed0", 32'(bus0.changed), 32'h0);
        check("idle.fall1",    32'(bus1.fall_out), 32'h0);

        // Single rising input: accepted on the ninth edge after the change.
        raw[0][0] = 1'b1;
        repeat (9) tick();
        check("lat.before", 32'(bus0.stable_out), 32'h0);
        tick();
        check("lat.stable", 32'(bus0.stable_out), 32'h1);
        check("lat.rise",   32'(bus0.rise_out),   32'h1);
        tick();
        check("lat.rise_one", 32'(bus0.rise_out), 32'h0);
        check("lat.changed",  32'(bus0.changed),  32'h1);

        // Glitches shorter than the debounce window are ignored.
        pulse_bit1(5);
        check("glitch5.changed", 32'(bus0.changed), 32'h1);
        pulse_bit1(7);
        check("glitch7.changed", 32'(bus0.changed), 32'h1);
        check("glitch7.stable",  32'(bus0.stable_out), 32'h1);
        pulse_bit1(8);
        check("pulse8.changed", 32'(bus0.changed), 32'h3);

        // All bits together, then a partial clear.
        raw[0] = 4'b0000;
        repeat (20) tick();
        clr[0] = 4'b1111;
        tick();
        clr[0] = 4'b0000;
        tick();
        check("clrall.changed", 32'(bus0.changed), 32'h0);
        raw[0] = 4'b1111;
        repeat (10) tick();
        check("all.rise", 32'(bus0.rise_out), 32'hF);
        tick();
        check("all.changed", 32'(bus0.changed), 32'hF);
        clr[0] = 4'b0101;
        tick();
        clr[0] = 4'b0000;
        check("partclr.changed", 32'(bus0.changed), 32'hA);

        // Clear landing in the same cycle as a fall pulse loses to the set.
        clr[0] = 4'b1111;
        tick();
        clr[0] = 4'b0000;
        tick();
        raw[0][2] = 1'b0;
        repeat (10) tick();
        check("setwins.fall", 32'(bus0.fall_out), 32'h4);
        clr[0] = 4'b0100;
        tick();
        clr[0] = 4'b0000;
        check("setwins.changed", 32'(bus0.changed), 32'h4);
        tick();
        check("setwins.hold", 32'(bus0.changed), 32'h4);

        // Reset in the middle of a count on the active-low instance.
        raw[1][3] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midrst.stable1", 32'(bus1.stable_out), 32'hF);
        check("midrst.fall1",   32'(bus1.fall_out),   32'h0);
        rst_n = 1'b1;
        repeat (9) tick();
        check("midrst.nofall", 32'(bus1.fall_out), 32'h0);
        tick();
        check("midrst.fall",   32'(bus1.fall_out),   32'h8);
        check("midrst.stable", 32'(bus1.stable_out), 32'h7);

        // Random toggling with hold times around the debounce window.
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 4; b++) hold[i][b] = 0;
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (hold[i][b] == 0) begin
                        raw[i][b]  = ~raw[i][b];
                        hold[i][b] = $urandom_range(1, 14);
                    end else begin
                        hold[i][b] = hold[i][b] - 1;
                    end
                end
                clr[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
